// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipeline_ctrl_pkg;

  // Sequencer state: running normally, or parked after a retired halt.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_t;

  // Architectural zero register; writes to it never create a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a source operand is really read and names the given register.
  function automatic logic src_hit(input logic used, input logic [4:0] src, input logic [4:0] rd);
    return used && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of datapath-facing signals for the pipeline sequencer.
//
// Memory handshake: imem_req_en / dmem_req_en are permissions to issue a
// request this cycle. A response (imem_resp / dmem_resp) is a one-cycle pulse
// that is consumed in the cycle it is seen; dmem_resp counts only while
// mem_req is high. Once consumed, the side does not request again until
// the pipeline advances, so a slow partner never causes a re-issue.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  // Datapath -> sequencer
  logic             imem_resp;
  logic             mem_req;
  logic             dmem_resp;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             wb_halt;
  // Sequencer -> datapath
  logic             imem_req_en;
  logic             dmem_req_en;
  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
  ctrl_state_t      state_dbg;

  modport master (
    output imem_resp, mem_req, dmem_resp, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_redirect, wb_halt,
    input  imem_req_en, dmem_req_en, load_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, flush_if_id, flush_id_ex, halted,
           cycle_cnt, stall_cnt, bubble_cnt, flush_cnt, state_dbg
  );

  modport slave (
    input  imem_resp, mem_req, dmem_resp, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_redirect, wb_halt,
    output imem_req_en, dmem_req_en, load_pc, load_if_id, load_id_ex, load_ex_mem,
           load_mem_wb, flush_if_id, flush_id_ex, halted,
           cycle_cnt, stall_cnt, bubble_cnt, flush_cnt, state_dbg
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
module pipeline_ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment on enable; natural overflow gives the wrap.
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + CNT_W'(1);
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns memory handshakes, load-use hazards, EX
// redirects and halt into per-stage load/flush strobes and perf counts.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        imem_done_q;
  logic        imem_done_d;
  logic        dmem_done_q;
  logic        dmem_done_d;
  logic        running;
  logic        front_ready;
  logic        back_ready;
  logic        advance;
  logic        hazard;
  logic        cyc_en;
  logic        stall_en;
  logic        bubble_en;
  logic        flush_en;

  // Readiness of both memory sides, advance decision and load-use detection.
  always_comb begin
    running     = (state_q == RUN) && !rst;
    front_ready = bus.imem_resp || imem_done_q;
    back_ready  = !bus.mem_req || bus.dmem_resp || dmem_done_q;
    advance     = running && front_ready && back_ready;
    hazard      = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                  (src_hit(bus.id_use_rs1, bus.id_rs1, bus.ex_rd) ||
                   src_hit(bus.id_use_rs2, bus.id_rs2, bus.ex_rd));
  end

  // State and sticky response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  // Next state: halt is terminal; flags remember early responses until advance.
  always_comb begin
    state_d     = state_q;
    imem_done_d = imem_done_q;
    dmem_done_d = dmem_done_q;
    if (state_q == RUN) begin
      if (bus.wb_halt) state_d = HALTED;
      if (advance) begin
        imem_done_d = 1'b0;
        dmem_done_d = 1'b0;
      end else begin
        imem_done_d = imem_done_q || bus.imem_resp;
        dmem_done_d = dmem_done_q || (bus.dmem_resp && bus.mem_req);
      end
    end
  end

  // Outputs: loads/flushes only on advance; a redirect overrides a load-use bubble.
  always_comb begin
    bus.load_pc     = 1'b0;
    bus.load_if_id  = 1'b0;
    bus.load_id_ex  = 1'b0;
    bus.load_ex_mem = 1'b0;
    bus.load_mem_wb = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.flush_id_ex = 1'b0;
    bus.imem_req_en = running && !imem_done_q;
    bus.dmem_req_en = running && bus.mem_req && !dmem_done_q;
    bus.halted      = (state_q == HALTED) && !rst;
    if (advance) begin
      bus.load_id_ex  = 1'b1;
      bus.load_ex_mem = 1'b1;
      bus.load_mem_wb = 1'b1;
      if (bus.ex_redirect) begin
        bus.load_pc     = 1'b1;
        bus.load_if_id  = 1'b1;
        bus.flush_if_id = 1'b1;
        bus.flush_id_ex = 1'b1;
      end else if (hazard) begin
        bus.flush_id_ex = 1'b1;
      end else begin
        bus.load_pc    = 1'b1;
        bus.load_if_id = 1'b1;
      end
    end
  end

  // Counter events.
  always_comb begin
    cyc_en    = running;
    stall_en  = running && !advance;
    bubble_en = advance && hazard && !bus.ex_redirect;
    flush_en  = advance && bus.ex_redirect;
  end

  assign bus.state_dbg = state_q;

  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .en(cyc_en), .count(bus.cycle_cnt)
  );
  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .en(stall_en), .count(bus.stall_cnt)
  );
  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .en(bubble_en), .count(bus.bubble_cnt)
  );
  pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .en(flush_en), .count(bus.flush_cnt)
  );
endmodule
